// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module  : serial_sub_pkg
// Brief   : State encodings and sizing helper for the bit-serial subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Bit counter must hold 0..WIDTH; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sub_slice.sv
// ============================================================================
// Module  : bit_sub_slice
// Brief   : Combinational full subtractor from two half subtractors and an OR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sub_slice (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_sub u_hs_ab (
    .a    (a),
    .b    (b),
    .d    (w_d1),
    .bout (w_b1)
  );

  half_sub u_hs_bin (
    .a    (w_d1),
    .b    (bin),
    .d    (d),
    .bout (w_b2)
  );

  assign bout = w_b1 | w_b2;

endmodule

`default_nettype wire

// File: rtl/half_sub.sv
// ============================================================================
// Module  : half_sub
// Brief   : 1-bit half subtractor (d = a - b, borrow when a=0 and b=1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module half_sub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

`default_nettype wire

// File: rtl/serial_subtractor_ctrl.sv
// ============================================================================
// Module  : serial_subtractor_ctrl
// Brief   : LSB-first bit-serial WIDTH-bit subtractor with valid/ready I/O.
//           Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_sh_a;
  logic [WIDTH-1:0]   r_sh_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   w_res_next;
  logic               r_borrow;
  logic               r_borrow_out;
  logic [CNT_W-1:0]   r_count;
  logic               w_d;
  logic               w_bo;
  logic               w_accept;
  logic               w_run;
  logic               w_last;

  bit_sub_slice u_slice (
    .a    (r_sh_a[0]),
    .b    (r_sh_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_accept = in_valid && in_ready;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_count == CNT_W'(WIDTH - 1));

  // Result register fills from the MSB end so bit 0 lands last.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_d;
    end else begin : g_res_wn
      assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (r_count == CNT_W'(WIDTH - 1)) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a       <= '0;
      r_sh_b       <= '0;
      r_res        <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_count      <= '0;
    end else if (w_accept) begin
      r_sh_a   <= a;
      r_sh_b   <= b;
      r_borrow <= 1'b0;
      r_count  <= '0;
    end else if (w_run) begin
      r_sh_a   <= r_sh_a >> 1;
      r_sh_b   <= r_sh_b >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_bo;
      r_count  <= r_count + CNT_W'(1);
      if (w_last) r_borrow_out <= w_bo;
    end
  end

  assign diff       = r_res;
  assign borrow_out = r_borrow_out;

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the last bit the shift registers hold the operand MSBs at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= (r_sh_a[0] ^ r_sh_b[0]) & (r_sh_a[0] ^ w_d);
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
// ============================================================================
// Module  : tb_serial_subtractor_ctrl
// Brief   : Directed self-checking bench for serial_subtractor_ctrl (WIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int total;
  int bad;
  int lat;

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h @%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Offer operands while in IDLE, then count edges until out_valid (bounded).
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, output int l);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_diff",      32'(diff),       32'd0);
    check("rst_borrow",    32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf",       32'(ovf),        32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 100 - 37 with latency and return-to-IDLE checks
    run_op(8'd100, 8'd37, lat);
    check("lat_100_37",    32'(lat),        32'd8);
    check("diff_100_37",   32'(diff),       32'd63);
    check("bo_100_37",     32'(borrow_out), 32'd0);
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready),   32'd1);
    check("idle_out_vld",  32'(out_valid),  32'd0);
    check("hold_diff_idle", 32'(diff),      32'd63);

    run_op(8'd5, 8'd10, lat);
    check("diff_5_10",     32'(diff),       32'hFB);
    check("bo_5_10",       32'(borrow_out), 32'd1);
    @(posedge clk); #1;

    run_op(8'h00, 8'hFF, lat);
    check("diff_00_ff",    32'(diff),       32'h01);
    check("bo_00_ff",      32'(borrow_out), 32'd1);
    @(posedge clk); #1;

    run_op(8'h3C, 8'h3C, lat);
    check("diff_eq",       32'(diff),       32'h00);
    check("bo_eq",         32'(borrow_out), 32'd0);
    @(posedge clk); #1;

    // Backpressure: result held, second operand pair waits
    out_ready = 1'b0;
    run_op(8'h55, 8'h22, lat);
    check("lat_bp",        32'(lat),        32'd8);
    @(negedge clk);
    a        = 8'h11;
    b        = 8'h22;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid),  32'd1);
      check("bp_diff",      32'(diff),       32'h33);
      check("bp_borrow",    32'(borrow_out), 32'd0);
      check("bp_in_ready",  32'(in_ready),   32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'(in_ready),  32'd1);
    check("bp_release_ov",   32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_acc",   32'(in_ready),  32'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat_second",    32'(lat),        32'd8);
    check("diff_second",   32'(diff),       32'hEF);
    check("bo_second",     32'(borrow_out), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    a        = 8'h90;
    b        = 8'h10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid),  32'd0);
    check("arst_diff",      32'(diff),       32'd0);
    check("arst_in_ready",  32'(in_ready),   32'd1);
    check("arst_borrow",    32'(borrow_out), 32'd0);
    repeat (10) begin
      @(negedge clk);
      check("arst_no_pulse", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;

    run_op(8'd200, 8'd1, lat);
    check("lat_200_1",     32'(lat),        32'd8);
    check("diff_200_1",    32'(diff),       32'd199);
    check("bo_200_1",      32'(borrow_out), 32'd0);
    @(posedge clk); #1;

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, lat);
    check("ovf_diff_80_01", 32'(diff),       32'h7F);
    check("ovf_80_01",      32'(ovf),        32'd1);
    check("ovf_bo_80_01",   32'(borrow_out), 32'd0);
    @(posedge clk); #1;
    run_op(8'h7F, 8'hFF, lat);
    check("ovf_diff_7f_ff", 32'(diff),       32'h80);
    check("ovf_7f_ff",      32'(ovf),        32'd1);
    check("ovf_bo_7f_ff",   32'(borrow_out), 32'd1);
    @(posedge clk); #1;
    run_op(8'h10, 8'h05, lat);
    check("ovf_diff_10_05", 32'(diff),       32'h0B);
    check("ovf_10_05",      32'(ovf),        32'd0);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
